bnn_fc_sequencer: RTL and testbench

BNN_FC_SEQUENCER -- requirements
Module: bnn_fc_sequencer

---
 rtl/bnn_fc_sequencer_if.sv | 27 ++
 rtl/bnn_fc_sequencer.sv | 90 +++++++++
 tb/tb_bnn_fc_sequencer.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/bnn_fc_sequencer_if.sv
// Control/result bus between the BNN FC pass sequencer and its FC engine and result consumer.
interface bnn_fc_sequencer_if;
    logic        go;
    logic        fc_start;
    logic [4:0]  state;
    logic [7:0]  raddr;
    logic [2:0]  cnt_stage_fc;
    logic [12:0] fc_data;
    logic        fc_end;
    logic        fc_finish;
    logic        res_valid;
    logic [12:0] res_data;
    logic [2:0]  res_idx;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        input  go, fc_data, fc_end, fc_finish, res_ready,
        output fc_start, state, raddr, cnt_stage_fc, res_valid, res_data, res_idx, busy, done, err
    );
    modport slave (
        output go, fc_data, fc_end, fc_finish, res_ready,
        input  fc_start, state, raddr, cnt_stage_fc, res_valid, res_data, res_idx, busy, done, err
    );
endinterface

// File: rtl/bnn_fc_sequencer.sv
// Drives NSTG fully-connected stages through the FC engine, collects one result per stage,
// then streams the results out; a per-stage watchdog aborts a stalled pass.
module bnn_fc_sequencer #(
    parameter int NSTG = 5,
    parameter int NRD  = 54,
    parameter int TMO  = 63
) (
    input  logic iCLK,
    input  logic iRST,
    bnn_fc_sequencer_if.master bus
);
    localparam int         WDW  = $clog2(TMO + 1);
    localparam logic [2:0] LAST = 3'(NSTG - 1);

    typedef enum logic [2:0] {IDLE, START, READ, WAIT, CAPT, FIN, DRAIN, DONE} st_t;

    st_t            st, nst;
    logic [7:0]     rd_cnt;
    logic [2:0]     stage, didx;
    logic [WDW-1:0] wd;
    logic [12:0]    res [NSTG];
    logic           tmo, err_c;

    // Watchdog saturates at TMO so a late CAPT still trips the check in FIN.
    assign tmo = (wd == WDW'(TMO));

    always_comb begin
        nst          = st;
        bus.fc_start = 1'b0;
        err_c        = 1'b0;
        bus.done     = 1'b0;
        case (st)
            IDLE:  if (bus.go) nst = START;
            START: begin bus.fc_start = 1'b1; nst = READ; end
            READ: begin
                if (bus.fc_end)                    nst = CAPT;
                else if (tmo)                      begin err_c = 1'b1; nst = IDLE; end
                else if (rd_cnt == 8'(NRD - 1))    nst = WAIT;
            end
            WAIT: begin
                if (bus.fc_end)  nst = CAPT;
                else if (tmo)    begin err_c = 1'b1; nst = IDLE; end
            end
            CAPT:  nst = (stage == LAST) ? FIN : START;
            FIN: begin
                if (bus.fc_finish) nst = DRAIN;
                else if (tmo)      begin err_c = 1'b1; nst = IDLE; end
            end
            DRAIN: if (bus.res_ready && didx == LAST) nst = DONE;
            DONE:  begin bus.done = 1'b1; nst = IDLE; end
            default: nst = IDLE;
        endcase
    end

    assign bus.err          = err_c;
    assign bus.busy         = (st != IDLE);
    assign bus.state        = bus.busy ? 5'd15 : 5'd0;
    assign bus.raddr        = (st == READ) ? rd_cnt : 8'd0;
    assign bus.cnt_stage_fc = stage;
    assign bus.res_valid    = (st == DRAIN);
    assign bus.res_data     = (st == DRAIN) ? res[didx] : 13'd0;
    assign bus.res_idx      = (st == DRAIN) ? didx : 3'd0;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            st     <= IDLE;
            rd_cnt <= '0;
            stage  <= '0;
            didx   <= '0;
            wd     <= '0;
            for (int i = 0; i < NSTG; i++) res[i] <= '0;
        end else begin
            st <= nst;
            if (st == IDLE && bus.go) stage <= '0;
            if (st == START) begin
                rd_cnt <= '0;
                wd     <= WDW'(1);
            end else if (st inside {READ, WAIT, CAPT, FIN} && !tmo) begin
                wd <= wd + 1'b1;
            end
            if (st == READ) rd_cnt <= rd_cnt + 8'd1;
            // The result is valid alongside the end strobe, so latch it on that edge.
            if (st inside {READ, WAIT} && bus.fc_end) res[stage] <= bus.fc_data;
            if (st == CAPT && stage != LAST) stage <= stage + 3'd1;
            if (st == FIN) didx <= '0;
            if (st == DRAIN && bus.res_ready && didx != LAST) didx <= didx + 3'd1;
            if (err_c) for (int i = 0; i < NSTG; i++) res[i] <= '0;
        end
    end
endmodule

// File: tb/tb_bnn_fc_sequencer.sv
// Bench for bnn_fc_sequencer: engine/consumer agent plus table-driven and random passes.
module tb_bnn_fc_sequencer;
    localparam int NSTG = 5;
    localparam int NRD  = 54;
    localparam int TMO  = 63;

    typedef struct {
        int          dly;      // cycles from start pulse to engine end strobe
        int          hang;     // stage that never ends; NSTG = none; 6 = finish never comes
        int          rmode;    // 0 ready=1, 1 pattern 1-0-0-1, 2 random
        logic [12:0] base;
        bit          busy_go;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bnn_fc_sequencer_if bus();
    bnn_fc_sequencer #(.NSTG(NSTG), .NRD(NRD), .TMO(TMO)) dut (.iCLK(clk), .iRST(rst), .bus(bus));

    int n_tests = 0, n_fail = 0;
    int cyc = 0, cnt = 0, eng_stg = -1;
    bit eng_act = 0, hung;
    int cfg_dly = 57, cfg_hang = NSTG, cfg_rmode = 0;
    logic [12:0] cfg_base = 13'h0A0;
    int starts[$], stg_q[$], err_cyc[$], got[$];
    int done_n, valid_n, raddr_err, hold_err, exp_ra;
    bit prev_v, prev_r;
    logic [12:0] prev_d;
    logic [2:0]  prev_i;

    task automatic chk(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        starts.delete(); stg_q.delete(); err_cyc.delete(); got.delete();
        done_n = 0; valid_n = 0; raddr_err = 0; hold_err = 0; prev_v = 0;
    endtask

    // Engine + consumer agent: inputs driven at the negedge, outputs sampled 1ns later.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                eng_act = 0; bus.fc_end = 0; bus.fc_finish = 0;
            end else begin
                if (bus.fc_start) begin
                    starts.push_back(cyc); stg_q.push_back(int'(bus.cnt_stage_fc));
                    eng_stg++; cnt = 0; eng_act = 1;
                end else if (eng_act) cnt++;
                hung = eng_act && (eng_stg == cfg_hang);
                bus.fc_end    = eng_act && !hung && cnt == cfg_dly;
                bus.fc_data   = bus.fc_end ? 13'(cfg_base + 13'(eng_stg)) : 13'($urandom);
                bus.fc_finish = eng_act && eng_stg == NSTG-1 && cfg_hang != 6 &&
                                (cnt == cfg_dly + 2 || cnt == cfg_dly + 3);
            end
            case (cfg_rmode)
                0:       bus.res_ready = 1'b1;
                1:       bus.res_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: bus.res_ready = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (!rst) begin
                exp_ra = (eng_act && cnt >= 1 && cnt <= NRD && (hung || cnt <= cfg_dly)) ? cnt - 1 : 0;
                if (int'(bus.raddr) != exp_ra) raddr_err++;
                if (bus.err) err_cyc.push_back(cyc);
                if (bus.done) done_n++;
                if (bus.res_valid) begin
                    valid_n++;
                    if (prev_v && !prev_r && (bus.res_data != prev_d || bus.res_idx != prev_i)) hold_err++;
                    if (bus.res_ready) got.push_back((int'(bus.res_idx) << 16) | int'(bus.res_data));
                end
                prev_v = bus.res_valid; prev_r = bus.res_ready;
                prev_d = bus.res_data;  prev_i = bus.res_idx;
            end
        end
    end

    task automatic run(vec_t v, string tag);
        int  exp_starts, hs, gap_err, stg_err;
        bit  fin, drain_go;
        cfg_dly = v.dly; cfg_hang = v.hang; cfg_rmode = v.rmode; cfg_base = v.base;
        eng_stg = -1; eng_act = 0;
        clr();
        @(negedge clk); #2 bus.go = 1'b1;
        @(negedge clk); #2 bus.go = 1'b0;
        fin = 0; drain_go = 0;
        for (int n = 0; n < 1500 && !fin; n++) begin
            @(negedge clk); #2;
            bus.go = 1'b0;
            if (v.busy_go && n == 10) bus.go = 1'b1;
            if (v.busy_go && bus.res_valid && !drain_go) begin bus.go = 1'b1; drain_go = 1; end
            fin = (done_n > 0) || (err_cyc.size() > 0);
        end
        for (int n = 0; n < 8; n++) begin @(negedge clk); #2 bus.go = 1'b0; end
        chk({tag, "_finished"}, int'(fin), 1);
        hs = (v.hang == 6) ? NSTG-1 : v.hang;
        exp_starts = (v.hang < NSTG) ? v.hang + 1 : NSTG;
        chk({tag, "_starts"}, starts.size(), exp_starts);
        gap_err = 0; stg_err = 0;
        foreach (starts[i]) begin
            if (i > 0 && starts[i] - starts[i-1] != v.dly + 2) gap_err++;
            if (stg_q[i] != i) stg_err++;
        end
        chk({tag, "_start_gaps"}, gap_err, 0);
        chk({tag, "_stage_idx"}, stg_err, 0);
        chk({tag, "_raddr"}, raddr_err, 0);
        if (v.hang < NSTG || v.hang == 6) begin
            chk({tag, "_err_n"}, err_cyc.size(), 1);
            chk({tag, "_err_time"},
                (err_cyc.size() > 0 && starts.size() > hs) ? err_cyc[0] - starts[hs] : -1, TMO);
            chk({tag, "_no_valid"}, valid_n, 0);
            chk({tag, "_no_done"}, done_n, 0);
        end else begin
            chk({tag, "_no_err"}, err_cyc.size(), 0);
            chk({tag, "_done_n"}, done_n, 1);
            chk({tag, "_hold"}, hold_err, 0);
            chk({tag, "_nres"}, got.size(), NSTG);
            foreach (got[i])
                chk({tag, "_res"}, got[i], (i << 16) | int'(13'(v.base + 13'(i))));
        end
        chk({tag, "_idle"}, int'({bus.busy, bus.state}), 0);
    endtask

    vec_t tbl[$];
    vec_t rv;
    int   r;
    bit   seen;

    initial begin
        bus.go = 0; bus.fc_end = 0; bus.fc_finish = 0; bus.fc_data = '0; bus.res_ready = 1;
        #2;
        chk("reset_outs", int'({bus.fc_start, bus.state, bus.raddr, bus.cnt_stage_fc, bus.res_valid,
                                bus.res_data, bus.res_idx, bus.busy, bus.done, bus.err}), 0);
        @(negedge clk); @(negedge clk); #2 rst = 1'b0;

        tbl.push_back('{57, NSTG, 0, 13'h0A0, 0});   // nominal
        tbl.push_back('{57, NSTG, 1, 13'h0A0, 0});   // backpressure
        tbl.push_back('{57, 2,    0, 13'h0A0, 0});   // stage 2 never ends
        tbl.push_back('{57, NSTG, 1, 13'h0A0, 1});   // go while busy
        tbl.push_back('{41, NSTG, 0, 13'h1B0, 0});   // early end at READ k=40
        tbl.push_back('{60, NSTG, 2, 13'h1FFE, 0});  // latest end, data wraps
        tbl.push_back('{1,  NSTG, 2, 13'h055, 0});   // end at READ k=0
        tbl.push_back('{57, 6,    0, 13'h0A0, 0});   // finish never arrives
        tbl.push_back('{57, NSTG-1, 1, 13'h0A0, 0}); // last stage never ends
        foreach (tbl[i]) run(tbl[i], $sformatf("v%0d", i));

        // Reset during stage 3 READ
        cfg_dly = 57; cfg_hang = NSTG; cfg_rmode = 0; cfg_base = 13'h0A0; eng_stg = -1;
        clr();
        @(negedge clk); #2 bus.go = 1'b1;
        @(negedge clk); #2 bus.go = 1'b0;
        seen = 0;
        for (int n = 0; n < 600 && !seen; n++) begin
            @(negedge clk); #2;
            seen = (bus.cnt_stage_fc == 3'd3) && (bus.raddr == 8'd10);
        end
        chk("rst_reached_stage3", int'(seen), 1);
        rst = 1'b1; #1;
        chk("rst_async_outs", int'({bus.fc_start, bus.state, bus.raddr, bus.cnt_stage_fc, bus.res_valid,
                                    bus.res_data, bus.res_idx, bus.busy, bus.done, bus.err}), 0);
        @(negedge clk); #2 rst = 1'b0;
        clr();
        repeat (100) @(negedge clk);
        chk("rst_no_pulse", done_n + err_cyc.size() + starts.size(), 0);
        run(tbl[0], "after_rst");

        for (int k = 0; k < 6; k++) begin
            r = $urandom_range(0, 9);
            rv.dly     = $urandom_range(1, 60);
            rv.hang    = (r < 4) ? r : ((r == 9) ? 6 : NSTG);
            rv.rmode   = $urandom_range(0, 2);
            rv.base    = 13'($urandom);
            rv.busy_go = 1'($urandom_range(0, 1));
            run(rv, $sformatf("rnd%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
